// File: rtl/dmx_1_2_32bits_stream_pkg.sv
// Shared defaults and width helper for the 1:2 32-bit stream demultiplexer.
package dmx_1_2_32bits_stream_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 2;

  // Number of bits needed to index `depth` entries (depth is a power of 2, >= 2).
  function automatic int ptr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmx_1_2_32bits_stream_fifo_sync_32bits.sv
// Single-clock FIFO with synchronous active-high reset that clears storage.
// The head entry is always driven from memory, so data written to an empty FIFO is not bypassed to the output.
module fifo_sync_32bits
  import dmx_1_2_32bits_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = ptr_w(DEPTH),
  parameter int CNT_W  = ptr_w(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      // Push and pop together leave the occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmx_1_2_32bits_stream.sv
// 1:2 demultiplexer for 32-bit streams: sl steers each input beat into one of two buffered channels.
// in_ready is built only from sl and registered FIFO state, never from the consumer ready inputs.
module dmx_1_2_32bits_stream
  import dmx_1_2_32bits_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = ptr_w(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sl,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [CNT_W-1:0]  out0_count,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  out1_count
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic xfer;

  assign in_ready   = !rst && (sl ? !full1 : !full0);
  assign xfer       = in_valid && in_ready;
  assign push0      = xfer && !sl;
  assign push1      = xfer && sl;
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  fifo_sync_32bits #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .pop       (out0_ready),
    .head_data (out0_data),
    .full      (full0),
    .empty     (empty0),
    .count     (out0_count)
  );

  fifo_sync_32bits #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .head_data (out1_data),
    .full      (full1),
    .empty     (empty1),
    .count     (out1_count)
  );

endmodule
